// File: rtl/hit_receiver.sv
// Hit receiver: accepts opponent hits, accumulates damage and scales launch velocity,
// then sequences hitstun and invulnerability lockouts with one 24-bit down-counter.
module hit_receiver #(
    parameter logic [23:0] HITSTUN_CYCLES = 24'd4194304,
    parameter logic [23:0] INVULN_CYCLES  = 24'd8388608
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] attack,
    input  logic [31:0] knockback,
    input  logic        respawn,
    output logic [31:0] damage,
    output logic [31:0] velocity,
    output logic        vel_valid,
    output logic        hitstun,
    output logic        invuln
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HITSTUN = 2'd1,
        ST_INVULN  = 2'd2
    } state_e;

    // A zero-length phase still lasts one cycle, so its reload value clamps at 0.
    localparam logic [23:0] HS_LOAD = (HITSTUN_CYCLES == 24'd0) ? 24'd0 : HITSTUN_CYCLES - 24'd1;
    localparam logic [23:0] IV_LOAD = (INVULN_CYCLES  == 24'd0) ? 24'd0 : INVULN_CYCLES  - 24'd1;
    localparam logic [10:0] DMG_MAX = 11'd999;

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [9:0]  dmg_q, dmg_d;
    logic [31:0] vel_q, vel_d;
    logic        vel_valid_q, vel_valid_d;
    logic        pend_q, pend_d;
    logic        hit_prev_q;

    logic        hit_ev;
    logic [3:0]  incr;
    logic [10:0] dmg_sum;
    logic [9:0]  dmg_sat;

    // v = k + floor(k*D/128), saturated to 16-bit signed; 27 bits hold k*D without overflow.
    function automatic logic [15:0] scale_axis(input logic [15:0] k, input logic [9:0] d);
        logic signed [26:0] k_ext;
        logic signed [26:0] d_ext;
        logic signed [26:0] prod;
        logic signed [26:0] sum;
        k_ext = {{11{k[15]}}, k};
        d_ext = {17'd0, d};
        prod  = k_ext * d_ext;
        sum   = k_ext + (prod >>> 7);
        if (sum > 27'sd32767)
            return 16'h7FFF;
        else if (sum < -27'sd32768)
            return 16'h8000;
        else
            return sum[15:0];
    endfunction

    assign hit_ev = (state_q == ST_IDLE) && attack[0] && attack[11] && !hit_prev_q;

    always_comb begin
        incr = 4'd0;
        if (|attack[4:1])
            incr = 4'd15;
        else if (attack[5])
            incr = 4'd3;
        else if (|attack[9:6])
            incr = 4'd8;
        else if (attack[10])
            incr = 4'd5;
    end

    assign dmg_sum = {1'b0, dmg_q} + {7'd0, incr};
    assign dmg_sat = (dmg_sum > DMG_MAX) ? DMG_MAX[9:0] : dmg_sum[9:0];

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dmg_d       = dmg_q;
        vel_d       = vel_q;
        vel_valid_d = 1'b0;
        pend_d      = 1'b0;

        if (respawn) begin
            state_d = ST_IDLE;
            cnt_d   = 24'd0;
            dmg_d   = 10'd0;
        end else begin
            // Knockback is valid the cycle after the hit, when dmg_q already holds post-hit damage.
            if (pend_q) begin
                vel_d       = {scale_axis(knockback[31:16], dmg_q), scale_axis(knockback[15:0], dmg_q)};
                vel_valid_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (hit_ev) begin
                        state_d = ST_HITSTUN;
                        cnt_d   = HS_LOAD;
                        dmg_d   = dmg_sat;
                        pend_d  = 1'b1;
                    end
                end
                ST_HITSTUN: begin
                    if (cnt_q == 24'd0) begin
                        state_d = ST_INVULN;
                        cnt_d   = IV_LOAD;
                    end else begin
                        cnt_d = cnt_q - 24'd1;
                    end
                end
                ST_INVULN: begin
                    if (cnt_q == 24'd0)
                        state_d = ST_IDLE;
                    else
                        cnt_d = cnt_q - 24'd1;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 24'd0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 24'd0;
            dmg_q       <= 10'd0;
            vel_q       <= 32'd0;
            vel_valid_q <= 1'b0;
            pend_q      <= 1'b0;
            hit_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dmg_q       <= dmg_d;
            vel_q       <= vel_d;
            vel_valid_q <= vel_valid_d;
            pend_q      <= pend_d;
            hit_prev_q  <= attack[0];
        end
    end

    assign damage    = {22'd0, dmg_q};
    assign velocity  = vel_q;
    assign vel_valid = vel_valid_q;
    assign hitstun   = (state_q == ST_HITSTUN);
    assign invuln    = (state_q == ST_INVULN);

endmodule

// File: doc/hit_receiver.md
HIT_RECEIVER -- requirements
Module: hit_receiver

Interface
REQ-001 Parameter: HITSTUN_CYCLES, 24'd4194304, number of cycles control lockout lasts after a hit.
REQ-002 Parameter: INVULN_CYCLES, 24'd8388608, number of cycles the character cannot be hit again after hitstun ends.
REQ-003 Port: clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: attack  input  32  opponent attack word: [0] hit landed, [1..4] smash U/D/L/R, [5] jab, [6..9] special U/D/L/R, [10] neutral special, [11] any attack active.
REQ-006 Port: knockback  input  32  opponent knockback, X signed [31:16], Y signed [15:0]; valid one cycle after attack[0] rises.
REQ-007 Port: respawn  input  1  single-cycle request to clear damage and return to IDLE.
REQ-008 Port: damage  output  32  accumulated damage percent in [9:0]; [31:10] always zero.
REQ-009 Port: velocity  output  32  scaled launch velocity, X signed [31:16], Y signed [15:0].
REQ-010 Port: vel_valid  output  1  one-cycle pulse qualifying velocity.
REQ-011 Port: hitstun  output  1  high while in HITSTUN; the movement logic ignores controls while it is high.
REQ-012 Port: invuln  output  1  high while in INVULN.

Function
REQ-013 The block SHALL implement the states IDLE, HITSTUN and INVULN, with a 24-bit down-counter.
REQ-014 A hit event SHALL be accepted in cycle T when the state is IDLE, attack[0]=1, attack[11]=1, and attack[0] was 0 in cycle T-1.
REQ-015 The attack[0] edge register SHALL update every cycle in every state, so an attack[0] that is held high is counted at most once.
REQ-016 Damage increment SHALL be taken from the lowest set bit of attack[10:1]: smash bits 1-4 = 15, jab bit 5 = 3, special bits 6-9 = 8, neutral special bit 10 = 5, none set = 0.
REQ-017 At T+1 the damage SHALL become min(damage + increment, 999); it saturates and never wraps.
REQ-018 At T+1 the knockback SHALL be sampled; each component SHALL be computed as v = k + floor((k * D) / 128), where D is the post-hit damage.
REQ-019 The product in REQ-018 SHALL be signed with at least 27 bits, using an arithmetic shift right by 7.
REQ-020 The sum in REQ-018 SHALL be saturated to the range [-32768, 32767].
REQ-021 velocity SHALL be registered at T+2, with vel_valid=1 for exactly that cycle; velocity holds its value otherwise.
REQ-022 IDLE SHALL go to HITSTUN at T+1, with the counter loaded to HITSTUN_CYCLES-1.
REQ-023 In HITSTUN, the counter SHALL decrement each cycle; at 0 the state SHALL move to INVULN with the counter loaded to INVULN_CYCLES-1.
REQ-024 In INVULN, at counter 0 the state SHALL return to IDLE.
REQ-025 A parameter value of 0 SHALL be treated as 1 cycle.
REQ-026 hitstun and invuln SHALL be Moore outputs decoded from the registered state.
REQ-027 Hits arriving in HITSTUN or INVULN SHALL be ignored: no damage, no velocity, no timer reload.
REQ-028 When respawn=1: damage SHALL go to 0, the state to IDLE, the counter to 0, and vel_valid to 0 in the next cycle.
REQ-029 respawn SHALL override a hit event in the same cycle.
REQ-030 A pending T+1 or T+2 hit update SHALL be cancelled when respawn is asserted.

Reset
REQ-031 reset SHALL take priority over respawn and hits.
REQ-032 Reset SHALL produce: damage=0, velocity=0, vel_valid=0, hitstun=0, invuln=0, state IDLE, counter 0, and attack[0] edge register 0.
REQ-033 Reset asserted mid-HITSTUN or mid-INVULN SHALL abort the sequence with no vel_valid pulse afterwards.

Verification
REQ-034 Smash hit from reset: attack=0x00000811 at T, knockback=0x080000E0 at T+1 -> damage=15 at T+1; velocity=0x08F000FA with vel_valid=1 at T+2; hitstun=1 from T+1.
REQ-035 Negative knockback: smashD attack=0x00000805, knockback=0x0000F7FE -> velocity=0x0000F70D (Y = -2050 + floor(-30750/128) = -2291).
REQ-036 Timers: HITSTUN_CYCLES=4, INVULN_CYCLES=3 -> hitstun high for T+1..T+4, invuln high for T+5..T+7, IDLE at T+8.
REQ-037 Timers, second hit: a second attack[0] edge arriving at T+6 is ignored (damage unchanged, no vel_valid).
REQ-038 Held hit: attack[0] held high for 20 cycles with small timer parameters -> exactly one damage increment.
REQ-039 Saturation: 67 jab-free smash hits -> damage=999; then knockback 0x70000000 -> velocity X=0x7FFF.
REQ-040 Respawn: respawn asserted in the same cycle as a hit edge -> damage=0, state IDLE, no vel_valid.
REQ-041 Reset mid-HITSTUN: reset asserted during HITSTUN -> all outputs 0 in the next cycle.
